// File: rtl/nes_loader.sv
// Hardware program loader: holds the 6502 in reset, streams an image into NES
// memory over the command word bus, patches the reset vector and starts the CPU.
module nes_loader #(
  parameter logic [15:0] BASE_ADDR   = 16'h8000,
  parameter logic [15:0] VEC_ADDR    = 16'hFFFC,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] length,
  input  logic [15:0] entry,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] cmd_writedata,
  output logic [15:0] cmd_address,
  output logic        cmd_write,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CW = 17;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [7:0] OP_RESET = 8'd0;
  localparam logic [7:0] OP_START = 8'd1;
  localparam logic [7:0] OP_PAUSE = 8'd2;
  localparam logic [7:0] OP_WRITE = 8'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_LOAD, S_VLO, S_VHI, S_PAUSE, S_GO
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [15:0]     len_q, len_nx;
  logic [15:0]     entry_q, entry_nx;
  logic [HW-1:0]   hold_q, hold_nx;
  logic [15:0]     wd_nx, addr_nx;
  logic            wr_nx, rdy_nx, busy_nx, done_nx;
  logic            xfer_c;

  // State, latched parameters and every output are registered together
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      len_q         <= '0;
      entry_q       <= '0;
      hold_q        <= '0;
      cmd_writedata <= {OP_RESET, 8'h00};
      cmd_address   <= 16'h0000;
      cmd_write     <= 1'b0;
      s_ready       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      len_q         <= len_nx;
      entry_q       <= entry_nx;
      hold_q        <= hold_nx;
      cmd_writedata <= wd_nx;
      cmd_address   <= addr_nx;
      cmd_write     <= wr_nx;
      s_ready       <= rdy_nx;
      busy          <= busy_nx;
      done          <= done_nx;
    end
  end

  // Next state and the command word that will be visible in that state
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    len_nx   = len_q;
    entry_nx = entry_q;
    hold_nx  = hold_q;
    wd_nx    = cmd_writedata;
    addr_nx  = cmd_address;
    wr_nx    = 1'b0;
    xfer_c   = s_valid && s_ready;

    if ((state != S_IDLE) && abort) begin
      // Abort wins over a simultaneous transfer; the byte is dropped
      state_nx = S_IDLE;
      wd_nx    = {OP_RESET, 8'h00};
      addr_nx  = 16'h0000;
      wr_nx    = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_nx = S_RST;
            len_nx   = length;
            entry_nx = entry;
            cnt_nx   = '0;
            hold_nx  = '0;
            wd_nx    = {OP_RESET, 8'h00};
            addr_nx  = 16'h0000;
            wr_nx    = 1'b1;
          end
        end
        S_RST: begin
          if (hold_q == HW'(HOLD_CYCLES - 1)) begin
            if (len_q == 16'h0000) begin
              state_nx = S_VLO;
              wd_nx    = {OP_WRITE, entry_q[7:0]};
              addr_nx  = VEC_ADDR;
              wr_nx    = 1'b1;
            end else begin
              state_nx = S_LOAD;
            end
          end else begin
            hold_nx = hold_q + HW'(1);
          end
        end
        S_LOAD: begin
          if (xfer_c) begin
            wd_nx   = {OP_WRITE, s_data};
            addr_nx = BASE_ADDR + cnt[15:0];
            wr_nx   = 1'b1;
            cnt_nx  = cnt + CW'(1);
          end else if (cnt == {1'b0, len_q}) begin
            state_nx = S_VLO;
            wd_nx    = {OP_WRITE, entry_q[7:0]};
            addr_nx  = VEC_ADDR;
            wr_nx    = 1'b1;
          end else begin
            wd_nx   = {OP_RESET, 8'h00};
            addr_nx = 16'h0000;
          end
        end
        S_VLO: begin
          state_nx = S_VHI;
          wd_nx    = {OP_WRITE, entry_q[15:8]};
          addr_nx  = VEC_ADDR + 16'd1;
          wr_nx    = 1'b1;
        end
        S_VHI: begin
          state_nx = S_PAUSE;
          wd_nx    = {OP_PAUSE, 8'h00};
          addr_nx  = 16'h0000;
          wr_nx    = 1'b1;
        end
        S_PAUSE: begin
          state_nx = S_GO;
          wd_nx    = {OP_START, 8'h00};
          addr_nx  = 16'h0000;
          wr_nx    = 1'b1;
        end
        S_GO: begin
          state_nx = S_IDLE;
        end
        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end

    rdy_nx  = (state_nx == S_LOAD) && (cnt_nx < {1'b0, len_nx});
    busy_nx = (state_nx != S_IDLE) && (state_nx != S_GO);
    done_nx = (state_nx == S_GO);
  end

endmodule

// File: tb/tb_nes_loader.sv
// Randomized bench for nes_loader: a trace model of the expected command
// sequence is compared against every cmd_write strobe of two instances.
module tb_nes_loader;

  localparam logic [15:0] BASE0 = 16'h8000;
  localparam logic [15:0] BASE1 = 16'hFFFE;
  localparam logic [15:0] VEC   = 16'hFFFC;
  localparam int          HOLD  = 4;

  logic        clk = 1'b0;
  logic        reset_n, start, abort, s_valid;
  logic [15:0] length, entry;
  logic [7:0]  s_data;
  logic        s_ready, cmd_write, busy, done;
  logic [15:0] cmd_writedata, cmd_address;
  logic        w_s_ready, w_cmd_write, w_busy, w_done;
  logic [15:0] w_cmd_writedata, w_cmd_address;

  nes_loader #(.BASE_ADDR(BASE0), .VEC_ADDR(VEC), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .length(length), .entry(entry), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .cmd_writedata(cmd_writedata), .cmd_address(cmd_address),
    .cmd_write(cmd_write), .busy(busy), .done(done));

  nes_loader #(.BASE_ADDR(BASE1), .VEC_ADDR(VEC), .HOLD_CYCLES(HOLD)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .length(length), .entry(entry), .s_data(s_data), .s_valid(s_valid),
    .s_ready(w_s_ready), .cmd_writedata(w_cmd_writedata), .cmd_address(w_cmd_address),
    .cmd_write(w_cmd_write), .busy(w_busy), .done(w_done));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed trace, sampled at the falling edge
  logic [15:0] ev_d[$], ev_a[$], w_d[$], w_a[$];
  int          ev_c[$];
  logic        ev_b[$];
  int done_n, done_cyc, first_ready, last_ready, ready_n, gap_bad;
  logic done_busy;

  always @(negedge clk) begin
    if (cmd_write) begin
      ev_d.push_back(cmd_writedata); ev_a.push_back(cmd_address);
      ev_c.push_back(cyc); ev_b.push_back(busy);
    end
    if (w_cmd_write) begin
      w_d.push_back(w_cmd_writedata); w_a.push_back(w_cmd_address);
    end
    if (done) begin done_n++; done_cyc = cyc; done_busy = busy; end
    if (s_ready) begin
      ready_n++; last_ready = cyc;
      if (first_ready < 0) first_ready = cyc;
    end
    if (busy && !cmd_write && cmd_writedata !== 16'h0000) gap_bad++;
  end

  logic [7:0] img[$];
  int         acc[$];

  // One load transaction: drive it, then compare the whole trace to the model
  task automatic test_load(input string name, input int n, input logic [15:0] ent,
                           input int mode, input int abort_at, input bit start_mid);
    int i, guard, e_cyc, abort_cyc, last;
    bit aborted;
    logic [15:0] x_d[$], x_a[$], y_a[$];
    int x_c[$];
    ev_d.delete(); ev_a.delete(); ev_c.delete(); ev_b.delete(); w_d.delete(); w_a.delete();
    acc.delete();
    done_n = 0; first_ready = -1; last_ready = -1; ready_n = 0; gap_bad = 0;
    @(negedge clk);
    length = 16'(n); entry = ent; start = 1'b1; e_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    i = 0; guard = 0; aborted = 0; abort_cyc = -1;
    while (i < n && !aborted && guard < 500) begin
      s_data = img[i];
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = guard[0];
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      abort = (i == abort_at);
      start = start_mid && (guard == 6);
      if (abort) begin aborted = 1; abort_cyc = cyc + 1; end
      else if (s_valid && s_ready) begin acc.push_back(cyc + 1); i++; end
      @(negedge clk);
      guard++;
    end
    s_valid = 1'b0; abort = 1'b0; start = 1'b0;
    n_chk++;
    if (guard >= 500) $display("FAIL %s stream_timeout accepted=%0d required=%0d", name, i, n);
    else n_pass++;
    if (!aborted) for (int k = 0; k < 20 && done_n == 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);

    // Reference trace built from the command sequence rules
    x_d.push_back(16'h0000); x_a.push_back(16'h0000); x_c.push_back(e_cyc); y_a.push_back(16'h0000);
    for (int k = 0; k < acc.size(); k++) begin
      x_d.push_back({8'h03, img[k]}); x_a.push_back(16'(BASE0 + k));
      y_a.push_back(16'(BASE1 + k)); x_c.push_back(acc[k]);
    end
    if (aborted) begin
      x_d.push_back(16'h0000); x_a.push_back(16'h0000); y_a.push_back(16'h0000); x_c.push_back(abort_cyc);
    end else begin
      last = (n == 0) ? e_cyc + HOLD - 1 : acc[n-1];
      x_d.push_back({8'h03, ent[7:0]});  x_a.push_back(VEC);
      x_d.push_back({8'h03, ent[15:8]}); x_a.push_back(VEC + 16'd1);
      x_d.push_back(16'h0200); x_a.push_back(16'h0000);
      x_d.push_back(16'h0100); x_a.push_back(16'h0000);
      for (int k = 1; k <= 4; k++) begin x_c.push_back(last + k); y_a.push_back(x_a[x_a.size()-5+k]); end
    end

    n_chk++;
    if (ev_d.size() !== x_d.size() || w_d.size() !== x_d.size())
      $display("FAIL %s n_cmds got=%0d/%0d required=%0d", name, ev_d.size(), w_d.size(), x_d.size());
    else n_pass++;
    for (int k = 0; k < x_d.size() && k < ev_d.size() && k < w_d.size(); k++) begin
      n_chk++;
      if (ev_d[k] !== x_d[k] || ev_a[k] !== x_a[k] || ev_c[k] !== x_c[k] ||
          w_d[k] !== x_d[k] || w_a[k] !== y_a[k])
        $display("FAIL %s cmd%0d got=%h@%h c%0d wrap=%h@%h required=%h@%h c%0d wrap@%h", name, k,
                 ev_d[k], ev_a[k], ev_c[k], w_d[k], w_a[k], x_d[k], x_a[k], x_c[k], y_a[k]);
      else n_pass++;
    end
    n_chk++;
    if (gap_bad !== 0) $display("FAIL %s idle_word_nonzero got=%0d required=0", name, gap_bad);
    else n_pass++;
    n_chk++;
    if (done_n !== (aborted ? 0 : 1)) $display("FAIL %s done_count got=%0d required=%0d", name, done_n, aborted ? 0 : 1);
    else n_pass++;
    if (!aborted && done_n == 1) begin
      n_chk++;
      if (done_cyc !== last + 4 || done_busy !== 1'b0)
        $display("FAIL %s done_timing got=c%0d busy=%b required=c%0d busy=0", name, done_cyc, done_busy, last + 4);
      else n_pass++;
    end
    if (aborted && ev_b.size() > 0) begin
      n_chk++;
      if (ev_b[ev_b.size()-1] !== 1'b0) $display("FAIL %s busy_on_abort got=1 required=0", name);
      else n_pass++;
    end
    n_chk++;
    if (n == 0 ? (ready_n !== 0) : (first_ready !== e_cyc + HOLD))
      $display("FAIL %s first_ready got=c%0d (n=%0d) required=c%0d", name, first_ready, ready_n, e_cyc + HOLD);
    else n_pass++;
    if (!aborted && n > 0) begin
      n_chk++;
      if (last_ready !== acc[n-1] - 1)
        $display("FAIL %s last_ready got=c%0d required=c%0d", name, last_ready, acc[n-1] - 1);
      else n_pass++;
    end
    n_chk++;
    if (busy !== 1'b0 || s_ready !== 1'b0) $display("FAIL %s end_idle busy=%b s_ready=%b required=0,0", name, busy, s_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 0; abort = 0; s_valid = 0; length = 0; entry = 0; s_data = 0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (cmd_writedata !== 16'h0000 || cmd_address !== 16'h0000 || cmd_write !== 1'b0 ||
        busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0 || w_cmd_write !== 1'b0)
      $display("FAIL reset got wd=%h a=%h wr=%b busy=%b rdy=%b done=%b required 0000,0000,0,0,0,0",
               cmd_writedata, cmd_address, cmd_write, busy, s_ready, done);
    else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    img = '{8'hA9, 8'h01, 8'h00};
    test_load("basic", 3, 16'h8000, 0, -1, 0);
  endtask

  task automatic test_throttled();
    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    test_load("throttled", 4, 16'hC123, 1, -1, 0);
  endtask

  task automatic test_zero_length();
    img.delete();
    test_load("zero_len", 0, 16'hBEEF, 0, -1, 0);
  endtask

  task automatic test_abort();
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    test_load("abort", 5, 16'h9000, 0, 2, 0);
    test_load("reload", 5, 16'h9000, 0, -1, 0);
  endtask

  task automatic test_start_during_load();
    img = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55, 8'hAA};
    test_load("start_mid", 6, 16'h8123, 1, -1, 1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int n;
      n = (r == 0) ? 0 : int'($urandom_range(1, 9));
      img.delete();
      for (int k = 0; k < n; k++) img.push_back(8'($urandom));
      test_load("random", n, 16'($urandom), int'($urandom_range(0, 2)), -1, r[0]);
    end
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    length = 16'd8; entry = 16'h8000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; s_valid = 1'b1; s_data = 8'h77;
    repeat (7) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_chk++;
    if (cmd_writedata !== 16'h0000 || cmd_address !== 16'h0000 || cmd_write !== 1'b0 ||
        busy !== 1'b0 || s_ready !== 1'b0 || done !== 1'b0)
      $display("FAIL async_reset got wd=%h a=%h wr=%b busy=%b rdy=%b done=%b required 0000,0000,0,0,0,0",
               cmd_writedata, cmd_address, cmd_write, busy, s_ready, done);
    else n_pass++;
    @(negedge clk);
    s_valid = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    img = '{8'h42, 8'h43};
    test_load("after_reset", 2, 16'h8800, 0, -1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_throttled();
    test_zero_length();
    test_abort();
    test_start_during_load();
    test_random();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
